// File: rtl/d_mulprod_gen.sv
// d_mulprod_gen: producer front end for the Dilithium reduction pipeline.
// Multiplies two CW-bit coefficients in a 2-stage stallable pipeline and
// presents the zero-extended product with its sideband tag and a range
// error flag on a valid/ready output.
module d_mulprod_gen #(
    parameter int              CW   = 23,
    parameter int              PW   = 48,
    parameter int              TAGW = 8,
    parameter logic [CW-1:0]   Dq   = 23'd8380417
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   in_a,
    input  logic [CW-1:0]   in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PW-1:0]   out_prod,
    output logic [TAGW-1:0] out_tag,
    output logic            out_err,
    output logic            busy
);

    // Operand b is split into a 12-bit low slice and the remaining high slice.
    localparam int LO_W    = 12;
    localparam int HI_W    = CW - LO_W;
    localparam int PPLO_W  = CW + LO_W;
    localparam int PPHI_W  = CW + HI_W;

    // Flags a pair whose operands are not valid residues mod Dq.
    function automatic logic range_err(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= Dq) | (b >= Dq);
    endfunction

    logic              adv_s;
    logic              err_s;
    logic [PPLO_W-1:0] pp_lo_s;
    logic [PPHI_W-1:0] pp_hi_s;
    logic [PW-1:0]     sum_s;

    logic              s1_valid_r;
    logic [PPLO_W-1:0] pp_lo_r;
    logic [PPHI_W-1:0] pp_hi_r;
    logic [TAGW-1:0]   s1_tag_r;
    logic              s1_err_r;

    logic              out_valid_r;
    logic [PW-1:0]     out_prod_r;
    logic [TAGW-1:0]   out_tag_r;
    logic              out_err_r;

    // Both stages advance together whenever the output register is free.
    assign adv_s    = ~out_valid_r | out_ready;
    assign in_ready = adv_s;

    // Stage-1 operand check and partial products; an errored pair yields zeros.
    always_comb begin
        err_s   = range_err(in_a, in_b);
        pp_lo_s = {PPLO_W{1'b0}};
        pp_hi_s = {PPHI_W{1'b0}};
        if (err_s) begin
            pp_lo_s = {PPLO_W{1'b0}};
            pp_hi_s = {PPHI_W{1'b0}};
        end else begin
            pp_lo_s = PPLO_W'(in_a) * PPLO_W'(in_b[LO_W-1:0]);
            pp_hi_s = PPHI_W'(in_a) * PPHI_W'(in_b[CW-1:LO_W]);
        end
    end

    // Stage-2 recombination of the two partial products.
    always_comb begin
        sum_s = PW'(pp_lo_r) + (PW'(pp_hi_r) << LO_W);
    end

    // Stage-1 register: captures an accepted pair whenever the pipe advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            pp_lo_r    <= {PPLO_W{1'b0}};
            pp_hi_r    <= {PPHI_W{1'b0}};
            s1_tag_r   <= {TAGW{1'b0}};
            s1_err_r   <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                pp_lo_r  <= pp_lo_s;
                pp_hi_r  <= pp_hi_s;
                s1_tag_r <= in_tag;
                s1_err_r <= err_s;
            end
        end
    end

    // Stage-2 output register: loads stage 1 on advance, holds under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_prod_r  <= {PW{1'b0}};
            out_tag_r   <= {TAGW{1'b0}};
            out_err_r   <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_prod_r <= sum_s;
                out_tag_r  <= s1_tag_r;
                out_err_r  <= s1_err_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_prod  = out_prod_r;
    assign out_tag   = out_tag_r;
    assign out_err   = out_err_r;
    assign busy      = s1_valid_r | out_valid_r;

endmodule

// File: tb/tb_d_mulprod_gen.sv
// Scoreboard bench for d_mulprod_gen: the driver pushes expected products
// on acceptance, a monitor pops and compares on every output transfer.
module tb_d_mulprod_gen;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] in_a;
    logic [22:0] in_b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_prod;
    logic [7:0]  out_tag;
    logic        out_err;
    logic        busy;

    typedef struct packed {
        logic [47:0] prod;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   run;
    int   last_run;
    int   tries;

    d_mulprod_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer one pair from a falling edge; push its expected result when accepted.
    task automatic send(input logic [22:0] a, input logic [22:0] b, input logic [7:0] t,
                        output int n);
        logic ok;
        exp_t e;
        logic [47:0] p;
        n  = 0;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        for (int k = 0; k < 50; k++) begin
            #1;
            ok = in_ready;
            n  = n + 1;
            @(posedge clk);
            if (ok) begin
                p      = 48'(a) * 48'(b);
                e.err  = (a >= 23'd8380417) || (b >= 23'd8380417);
                e.prod = e.err ? 48'd0 : p;
                e.tag  = t;
                sb.push_back(e);
                break;
            end
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Monitor: compare every output transfer against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && out_valid && out_ready) begin
                run = run + 1;
                if (sb.size() == 0) begin
                    chk("unexpected_out", {56'd0, out_tag}, 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_prod", {16'd0, out_prod}, {16'd0, e.prod});
                    chk("out_tag",  {56'd0, out_tag},  {56'd0, e.tag});
                    chk("out_err",  {63'd0, out_err},  {63'd0, e.err});
                end
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        run       = 0;
        last_run  = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = 23'd0;
        in_b      = 23'd0;
        in_tag    = 8'd0;
        out_ready = 1'b0;

        // Reset state
        cycles(3);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_prod",  {16'd0, out_prod},  64'd0);
        chk("rst_out_tag",   {56'd0, out_tag},   64'd0);
        chk("rst_out_err",   {63'd0, out_err},   64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single pair and 2-cycle latency
        out_ready = 1'b1;
        send(23'd3, 23'd5, 8'h11, tries);
        @(negedge clk); #1;
        chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
        chk("lat_cycle1_busy",  {63'd0, busy},      64'd1);
        @(negedge clk); #1;
        chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_cycle2_prod",  {16'd0, out_prod},  64'h00000000000F);
        cycles(3);

        // Maximum operands and range-check boundaries
        send(23'd8380416, 23'd8380416, 8'h22, tries);
        send(23'd8380417, 23'd2,       8'h5A, tries);
        send(23'd2,       23'd8380417, 8'h5B, tries);
        send(23'h7FFFFF,  23'h7FFFFF,  8'h5C, tries);
        send(23'd0,       23'd8380416, 8'h5D, tries);
        cycles(5);
        chk("max_model_const", 48'(23'd8380416) * 48'(23'd8380416), 64'h3FE004000000);

        // Streaming 16 back-to-back pairs
        run      = 0;
        last_run = 0;
        for (int i = 0; i < 16; i++) begin
            send(23'(i), 23'(i + 1), 8'(i), tries);
            chk("stream_in_ready_first_try", 64'(tries), 64'd1);
        end
        cycles(6);
        chk("stream_consecutive_valid", 64'(last_run), 64'd16);

        // Backpressure with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        send(23'd1000,    23'd2000, 8'h01, tries);
        send(23'd8380416, 23'd4095, 8'h02, tries);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 23'd77;
        in_b     = 23'd99;
        in_tag   = 8'h03;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_in_ready",  {63'd0, in_ready},  64'd0);
            chk("stall_busy",      {63'd0, busy},      64'd1);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_out_tag",   {56'd0, out_tag},   64'h01);
            chk("stall_out_prod",  {16'd0, out_prod},  64'd2000000);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        sb.push_back('{prod: 48'd7623, tag: 8'h03, err: 1'b0});
        #1;
        in_valid = 1'b0;
        cycles(6);
        chk("bp_sb_drained", 64'(sb.size()), 64'd0);

        // Reset mid-stream with two pairs in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(23'd10, 23'd20, 8'h21, tries);
        send(23'd30, 23'd40, 8'h22, tries);
        @(negedge clk);
        #5;
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_busy",      {63'd0, busy},      64'd0);
        chk("midrst_out_prod",  {16'd0, out_prod},  64'd0);
        chk("midrst_out_tag",   {56'd0, out_tag},   64'd0);
        sb.delete();
        out_ready = 1'b1;
        cycles(2);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        cycles(6);
        send(23'd7, 23'd6, 8'h33, tries);
        cycles(5);
        chk("final_sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
